mc_main_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS core. Decodes opcode per instruction and sequences the

---
 rtl/mc_main_ctrl_if.sv | 33 +++
 rtl/mc_main_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mc_main_ctrl_if.sv
// Control/status bundle between the multicycle main control FSM and the shared datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface mc_main_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, mem_timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences the shared ALU, unified memory
// and IR/A/B/ALUOut registers per opcode, with a memory-ready stall and an access timeout.
module mc_main_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_main_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BEQ    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_wait_st;
    logic             w_timeout;

    // Wait-state qualification and timeout detection on the final allowed cycle.
    always_comb begin
        w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_timeout = TIMEOUT_EN && w_wait_st && !bus.mem_ready &&
                    (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter: counts stalled cycles, zero whenever the FSM is not stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (TIMEOUT_EN && w_wait_st && !bus.mem_ready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state and Moore/strobe output decode.
    always_comb begin
        w_state_nxt     = r_state;
        bus.mem_req     = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_op      = 2'b00;
        bus.pc_src      = 2'b00;
        bus.pc_en       = 1'b0;
        bus.illegal_op  = 1'b0;
        bus.mem_timeout = w_timeout;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                // A timed-out fetch re-enters FETCH with the PC untouched.
                if (bus.mem_ready) begin
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_RTYPE:     w_state_nxt = S_EXEC;
                    OP_BEQ:       w_state_nxt = S_BEQ;
                    OP_ADDI:      w_state_nxt = S_ADDIEX;
                    OP_J:         w_state_nxt = S_JUMP;
                    default: begin
                        w_state_nxt    = S_FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OP_LW) begin
                    w_state_nxt = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    w_state_nxt = S_MEMWR;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    w_state_nxt = S_MEMWB;
                end else if (w_timeout) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                w_state_nxt    = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_write = bus.mem_ready;
                if (bus.mem_ready || w_timeout) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_MEMWR;
                end
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                w_state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
                w_state_nxt   = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                w_state_nxt   = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src  = 2'b10;
                bus.pc_en   = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: the driver queues the hand-derived output word for each
// cycle, and a negedge monitor pops and compares it against the live control outputs.
module tb_mc_main_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.TIMEOUT_CYC(16), .TIMEOUT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output word: {mem_req, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
    //               alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], pc_en, illegal_op, mem_timeout}
    localparam logic [16:0] E_IDLE      = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_FETCH_RDY = 17'b1_0_0_1_0_0_0_0_01_00_00_1_0_0;
    localparam logic [16:0] E_FETCH_WT  = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [16:0] E_FETCH_TO  = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_1;
    localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [16:0] E_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_11_00_00_0_1_0;
    localparam logic [16:0] E_MEMADR    = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] E_MEMRD     = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_MEMWB     = 17'b0_0_0_0_1_0_1_0_00_00_00_0_0_0;
    localparam logic [16:0] E_MEMWR_RDY = 17'b1_1_1_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_MEMWR_WT  = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_MEMWR_TO  = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_1;
    localparam logic [16:0] E_EXEC      = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
    localparam logic [16:0] E_ALUWB     = 17'b0_0_0_0_1_1_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_BEQ_Z1    = 17'b0_0_0_0_0_0_0_1_00_01_01_1_0_0;
    localparam logic [16:0] E_BEQ_Z0    = 17'b0_0_0_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [16:0] E_ADDIEX    = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [16:0] E_ADDIWB    = 17'b0_0_0_0_1_0_0_0_00_00_00_0_0_0;
    localparam logic [16:0] E_JUMP      = 17'b0_0_0_0_0_0_0_0_00_00_10_1_0_0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_vec  = 0;
    int       n_fail = 0;

    logic [16:0] w_act;
    assign w_act = {bus.mem_req, bus.iord, bus.mem_write, bus.ir_write, bus.reg_write,
                    bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.pc_src, bus.pc_en, bus.illegal_op, bus.mem_timeout};

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            n_vec = n_vec + 1;
            if (w_act !== it.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %b expected %b", it.name, w_act, it.exp);
            end
        end
    end

    task automatic step(input logic rst_v, input logic [5:0] opc, input logic z,
                        input logic rdy, input logic [16:0] exp, input string name);
        sb_item_t it;
        rst_n         = rst_v;
        bus.opcode    = opc;
        bus.zero      = z;
        bus.mem_ready = rdy;
        it.exp        = exp;
        it.name       = name;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, OP_RTYPE, 1'b0, 1'b1, E_IDLE, "reset_hold");
        step(1'b1, OP_RTYPE, 1'b0, 1'b1, E_IDLE, "idle_after_reset");

        step(1'b1, OP_RTYPE, 1'b0, 1'b1, E_FETCH_RDY, "r_fetch");
        step(1'b1, OP_RTYPE, 1'b0, 1'b1, E_DECODE,    "r_decode");
        step(1'b1, OP_RTYPE, 1'b0, 1'b1, E_EXEC,      "r_exec");
        step(1'b1, OP_RTYPE, 1'b0, 1'b1, E_ALUWB,     "r_aluwb");

        step(1'b1, OP_LW, 1'b0, 1'b1, E_FETCH_RDY, "lw_fetch");
        step(1'b1, OP_LW, 1'b0, 1'b1, E_DECODE,    "lw_decode");
        step(1'b1, OP_LW, 1'b0, 1'b1, E_MEMADR,    "lw_memadr");
        for (int i = 0; i < 3; i++) step(1'b1, OP_LW, 1'b0, 1'b0, E_MEMRD, "lw_memrd_wait");
        step(1'b1, OP_LW, 1'b0, 1'b1, E_MEMRD,     "lw_memrd_done");
        step(1'b1, OP_LW, 1'b0, 1'b1, E_MEMWB,     "lw_memwb");

        step(1'b1, OP_BEQ, 1'b1, 1'b1, E_FETCH_RDY, "beq1_fetch");
        step(1'b1, OP_BEQ, 1'b1, 1'b1, E_DECODE,    "beq1_decode");
        step(1'b1, OP_BEQ, 1'b1, 1'b1, E_BEQ_Z1,    "beq_taken");
        step(1'b1, OP_BEQ, 1'b0, 1'b1, E_FETCH_RDY, "beq0_fetch");
        step(1'b1, OP_BEQ, 1'b0, 1'b1, E_DECODE,    "beq0_decode");
        step(1'b1, OP_BEQ, 1'b0, 1'b1, E_BEQ_Z0,    "beq_not_taken");

        step(1'b1, OP_ADDI, 1'b0, 1'b1, E_FETCH_RDY, "addi_fetch");
        step(1'b1, OP_ADDI, 1'b0, 1'b1, E_DECODE,    "addi_decode");
        step(1'b1, OP_ADDI, 1'b0, 1'b1, E_ADDIEX,    "addi_ex");
        step(1'b1, OP_ADDI, 1'b0, 1'b1, E_ADDIWB,    "addi_wb");

        step(1'b1, OP_J, 1'b0, 1'b1, E_FETCH_RDY, "j_fetch");
        step(1'b1, OP_J, 1'b0, 1'b1, E_DECODE,    "j_decode");
        step(1'b1, OP_J, 1'b0, 1'b1, E_JUMP,      "j_jump");

        step(1'b1, OP_BAD, 1'b0, 1'b1, E_FETCH_RDY, "ill_fetch");
        step(1'b1, OP_BAD, 1'b0, 1'b1, E_DEC_ILL,   "ill_decode");

        step(1'b1, OP_SW, 1'b0, 1'b1, E_FETCH_RDY, "sw_fetch");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_DECODE,    "sw_decode");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_MEMADR,    "sw_memadr");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_MEMWR_RDY, "sw_memwr");

        step(1'b1, OP_SW, 1'b0, 1'b1, E_FETCH_RDY, "swto_fetch");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_DECODE,    "swto_decode");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_MEMADR,    "swto_memadr");
        for (int i = 0; i < 15; i++) step(1'b1, OP_SW, 1'b0, 1'b0, E_MEMWR_WT, "swto_wait");
        step(1'b1, OP_SW, 1'b0, 1'b0, E_MEMWR_TO, "swto_timeout");

        // Fetch timeout retries, then a fetch whose data arrives on the last allowed cycle.
        for (int i = 0; i < 15; i++) step(1'b1, OP_J, 1'b0, 1'b0, E_FETCH_WT, "fto_wait");
        step(1'b1, OP_J, 1'b0, 1'b0, E_FETCH_TO, "fto_timeout");
        for (int i = 0; i < 15; i++) step(1'b1, OP_J, 1'b0, 1'b0, E_FETCH_WT, "flast_wait");
        step(1'b1, OP_J, 1'b0, 1'b1, E_FETCH_RDY, "flast_ready");
        step(1'b1, OP_J, 1'b0, 1'b1, E_DECODE,    "flast_decode");
        step(1'b1, OP_J, 1'b0, 1'b1, E_JUMP,      "flast_jump");

        step(1'b1, OP_SW, 1'b0, 1'b1, E_FETCH_RDY, "rst_fetch");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_DECODE,    "rst_decode");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_MEMADR,    "rst_memadr");
        step(1'b1, OP_SW, 1'b0, 1'b0, E_MEMWR_WT,  "rst_memwr_wait");
        step(1'b0, OP_SW, 1'b0, 1'b1, E_IDLE,      "rst_mid_memwr");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_IDLE,      "rst_release_idle");
        step(1'b1, OP_SW, 1'b0, 1'b1, E_FETCH_RDY, "rst_release_fetch");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
